// File: rtl/isa_pkg.sv
// Shared ISA definitions for the downsampling processor: opcodes, sequencer
// state encoding and default widths used by the sequencer and datapath.
package isa_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_STACK_D = 4;

  localparam logic [3:0] OP_JMP   = 4'h1;
  localparam logic [3:0] OP_JMPZ  = 4'h2;
  localparam logic [3:0] OP_JMPNZ = 4'h3;
  localparam logic [3:0] OP_CALL  = 4'h4;
  localparam logic [3:0] OP_RET   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes resolved entirely by the sequencer; everything else goes to the datapath.
  function automatic logic is_ctrl_op(input logic [3:0] op);
    logic res;
    case (op)
      OP_JMP, OP_JMPZ, OP_JMPNZ, OP_CALL, OP_RET, OP_HALT: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for CALL/RET. Push and pop are ignored when the
// stack is full or empty respectively; the caller reports those as errors.
module return_stack
  import isa_pkg::*;
#(
  parameter int STACK_D = DEF_STACK_D,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] top
);

  localparam int PTR_W = $clog2(STACK_D);

  logic [PTR_W:0]    r_sp;
  logic [ADDR_W-1:0] r_mem [STACK_D];
  logic [PTR_W-1:0]  w_top_idx;

  // Occupancy flags and the entry a RET would return to.
  always_comb begin
    full      = (r_sp == (PTR_W+1)'(STACK_D));
    empty     = (r_sp == {(PTR_W+1){1'b0}});
    w_top_idx = r_sp[PTR_W-1:0] - PTR_W'(1'b1);
    top       = r_mem[w_top_idx];
  end

  // Stack pointer: counts valid entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (clr) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + (PTR_W+1)'(1'b1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - (PTR_W+1)'(1'b1);
    end
  end

  // Entry storage, written at the current pointer on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_D; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push && !full && !clr) begin
      r_mem[r_sp[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: owns the PC, drives instruction fetch,
// resolves jumps/branches/calls and hands other opcodes to the datapath.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int STACK_D = DEF_STACK_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               alu_zero,
  output logic               exec_start,
  input  logic               exec_done,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               err
);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_halted;
  logic               r_err;

  logic [3:0]         w_opcode;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_push;
  logic               w_pop;
  logic               w_clr;
  logic               w_exec_start;
  logic               w_full;
  logic               w_empty;
  logic [ADDR_W-1:0]  w_top;

  assign w_opcode = r_ir[INSTR_W-1 -: 4];
  assign w_target = r_ir[ADDR_W-1:0];
  assign w_pc_inc = r_pc + ADDR_W'(1'b1);

  // Decode-cycle controls for the stack and datapath launch.
  always_comb begin
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_exec_start = 1'b0;
    w_clr        = 1'b0;
    if (r_state == ST_DECODE) begin
      w_push       = (w_opcode == OP_CALL) && !w_full;
      w_pop        = (w_opcode == OP_RET) && !w_empty;
      w_exec_start = !is_ctrl_op(w_opcode);
    end else begin
      w_clr = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    end
  end

  return_stack #(
    .STACK_D (STACK_D),
    .ADDR_W  (ADDR_W)
  ) u_return_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .full      (w_full),
    .empty     (w_empty),
    .top       (w_top)
  );

  // Main sequencing FSM with registered pc/ir/status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (w_opcode)
            OP_JMP: begin
              r_pc    <= w_target;
              r_state <= ST_FETCH;
            end
            OP_JMPZ: begin
              r_pc    <= alu_zero ? w_target : w_pc_inc;
              r_state <= ST_FETCH;
            end
            OP_JMPNZ: begin
              r_pc    <= alu_zero ? w_pc_inc : w_target;
              r_state <= ST_FETCH;
            end
            OP_CALL: begin
              if (!w_full) begin
                r_pc    <= w_target;
                r_state <= ST_FETCH;
              end else begin
                r_err    <= 1'b1;
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
              end
            end
            OP_RET: begin
              if (!w_empty) begin
                r_pc    <= w_top;
                r_state <= ST_FETCH;
              end else begin
                r_err    <= 1'b1;
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
              end
            end
            OP_HALT: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
            default: begin
              r_state <= ST_EXEC;
            end
          endcase
        end
        ST_EXEC: begin
          if (exec_done) begin
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (start) begin
            r_pc     <= '0;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
            r_state  <= ST_FETCH;
          end
        end
        default: begin
          r_halted <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req   = (r_state == ST_FETCH);
  assign imem_addr  = r_pc;
  assign exec_start = w_exec_start;
  assign ir         = r_ir;
  assign pc         = r_pc;
  assign halted     = r_halted;
  assign err        = r_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: behavioural instruction memory and
// datapath responders, fetch-address scoreboard, vector table plus corner sequences.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        alu_zero;
  logic        exec_start;
  logic        exec_done = 1'b0;
  logic [15:0] ir;
  logic [11:0] pc;
  logic        halted;
  logic        err;

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .alu_zero   (alu_zero),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .ir         (ir),
    .pc         (pc),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  int          fetch_lat = 0;
  int          exec_lat  = 1;

  logic [11:0] obs_q [$];
  int          n_req = 0;
  int          n_unstable = 0;
  int          n_exec = 0;
  int          lat_cnt = 0;
  int          ecnt = 0;
  logic [11:0] held_addr = 12'h000;

  // Memory and datapath models; they respond on the falling edge.
  always @(negedge clk) begin
    if (imem_req) begin
      n_req++;
      if (lat_cnt != 0 && imem_addr != held_addr) n_unstable++;
      if (lat_cnt == 0) held_addr = imem_addr;
      if (lat_cnt >= fetch_lat) begin
        imem_ready = 1'b1;
        imem_rdata = mem[imem_addr];
        obs_q.push_back(imem_addr);
        lat_cnt = 0;
      end else begin
        imem_ready = 1'b0;
        lat_cnt++;
      end
    end else begin
      if (lat_cnt != 0 && rst_n) n_unstable++;
      imem_ready = 1'b0;
      lat_cnt = 0;
    end
    if (exec_start) begin
      n_exec++;
      ecnt = exec_lat;
      exec_done = 1'b0;
    end else if (ecnt > 0) begin
      ecnt--;
      exec_done = (ecnt == 0);
    end else begin
      exec_done = 1'b0;
    end
  end

  typedef struct {
    logic [11:0] at_pc;
    logic [15:0] instr;
    logic        zero;
    logic [11:0] exp_next;
  } vec_t;

  vec_t        vecs [8];
  logic [11:0] exp_q [$];
  int          consumed = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          snap;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch_lat = 0;
    exec_lat  = 1;
    #1;
    consumed = obs_q.size();
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  // Pop expected fetch addresses as the memory model records each fetch.
  task automatic drain(input string nm);
    int budget;
    budget = 300;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
      while (consumed < obs_q.size() && exp_q.size() > 0) begin
        check(nm, 32'(obs_q[consumed]), 32'(exp_q.pop_front()));
        consumed++;
      end
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout actual=%0d_fetches_pending required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_halted(input string nm);
    int budget;
    budget = 200;
    while (!halted && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check(nm, 32'(halted), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    alu_zero = 1'b0;
    fill_halt();

    vecs[0] = '{12'h005, 16'h1ABC, 1'b0, 12'hABC};
    vecs[1] = '{12'h005, 16'h2010, 1'b0, 12'h006};
    vecs[2] = '{12'h005, 16'h2010, 1'b1, 12'h010};
    vecs[3] = '{12'h007, 16'h3020, 1'b0, 12'h020};
    vecs[4] = '{12'h007, 16'h3020, 1'b1, 12'h008};
    vecs[5] = '{12'hFFF, 16'h0000, 1'b0, 12'h000};
    vecs[6] = '{12'h123, 16'h6000, 1'b1, 12'h124};
    vecs[7] = '{12'h010, 16'h4300, 1'b0, 12'h300};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_exec_start", 32'(exec_start), 32'h0);

    // Straight-line program, exec_done two cycles after each launch.
    do_reset();
    fill_halt();
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h0000;
    exec_lat = 2;
    snap = n_exec;
    exp_q.push_back(12'h000); exp_q.push_back(12'h001);
    exp_q.push_back(12'h002); exp_q.push_back(12'h003);
    pulse_start();
    drain("seq_fetch");
    wait_halted("seq_halted");
    check("seq_exec_count", 32'(n_exec - snap), 32'd3);
    check("seq_pc", 32'(pc), 32'h003);
    check("seq_ir", 32'(ir), 32'hF000);

    // Single-instruction vectors reached through a JMP at address 0.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      fill_halt();
      mem[0] = 16'h1000 | 16'(vecs[v].at_pc);
      mem[vecs[v].at_pc] = vecs[v].instr;
      alu_zero = vecs[v].zero;
      exp_q.push_back(12'h000);
      exp_q.push_back(vecs[v].at_pc);
      exp_q.push_back(vecs[v].exp_next);
      pulse_start();
      drain($sformatf("vec%0d_fetch", v));
    end
    alu_zero = 1'b0;

    // CALL then RET returns to the instruction after the call.
    do_reset();
    fill_halt();
    mem[0] = 16'h1020; mem[12'h020] = 16'h4100; mem[12'h100] = 16'h5000;
    exp_q.push_back(12'h000); exp_q.push_back(12'h020);
    exp_q.push_back(12'h100); exp_q.push_back(12'h021);
    pulse_start();
    drain("callret_fetch");
    wait_halted("callret_halted");
    check("callret_err", 32'(err), 32'h0);
    check("callret_pc", 32'(pc), 32'h021);

    // Five nested calls overflow the 4-deep stack.
    do_reset();
    fill_halt();
    for (int i = 0; i < 5; i++) mem[i] = 16'h4000 | 16'(i + 1);
    for (int i = 0; i < 5; i++) exp_q.push_back(12'(i));
    pulse_start();
    drain("ovf_fetch");
    wait_halted("ovf_halted");
    check("ovf_err", 32'(err), 32'h1);
    check("ovf_pc", 32'(pc), 32'h004);

    // Restart from HALT: err and stack must be cleared.
    mem[0] = 16'h4010; mem[1] = 16'hF000; mem[12'h010] = 16'h5000;
    exp_q.push_back(12'h000); exp_q.push_back(12'h010); exp_q.push_back(12'h001);
    pulse_start();
    drain("restart_fetch");
    wait_halted("restart_halted");
    check("restart_err", 32'(err), 32'h0);
    check("restart_pc", 32'(pc), 32'h001);

    // RET on an empty stack.
    do_reset();
    fill_halt();
    mem[0] = 16'h5000;
    exp_q.push_back(12'h000);
    pulse_start();
    drain("unf_fetch");
    wait_halted("unf_halted");
    check("unf_err", 32'(err), 32'h1);
    check("unf_pc", 32'(pc), 32'h000);
    mem[0] = 16'h0000; mem[1] = 16'hF000;
    exp_q.push_back(12'h000); exp_q.push_back(12'h001);
    pulse_start();
    drain("unf_restart_fetch");
    wait_halted("unf_restart_halted");
    check("unf_restart_err", 32'(err), 32'h0);
    check("unf_restart_pc", 32'(pc), 32'h001);

    // CALL at 0xFFF pushes 0x000.
    do_reset();
    fill_halt();
    mem[0] = 16'h1FFF; mem[12'hFFF] = 16'h4200; mem[12'h200] = 16'h5000;
    exp_q.push_back(12'h000); exp_q.push_back(12'hFFF);
    exp_q.push_back(12'h200); exp_q.push_back(12'h000);
    pulse_start();
    drain("callwrap_fetch");

    // Slow memory: request and address held through a 3-cycle wait.
    do_reset();
    fill_halt();
    mem[0] = 16'h0000;
    fetch_lat = 3;
    snap = n_req;
    exp_q.push_back(12'h000); exp_q.push_back(12'h001);
    begin
      int unst0;
      unst0 = n_unstable;
      pulse_start();
      drain("slow_fetch");
      wait_halted("slow_halted");
      check("slow_unstable", 32'(n_unstable - unst0), 32'd0);
      check("slow_req_cycles", 32'(n_req - snap), 32'd8);
    end

    // Reset during a pending fetch drops imem_req at once.
    do_reset();
    fill_halt();
    mem[0] = 16'h0000;
    fetch_lat = 3;
    pulse_start();
    @(negedge clk);
    #2;
    check("abort_req_before", 32'(imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_req_after", 32'(imem_req), 32'h0);

    // Reset during EXEC; the late exec_done must be ignored.
    do_reset();
    fill_halt();
    mem[0] = 16'h1005; mem[5] = 16'h0000;
    exec_lat = 6;
    snap = n_exec;
    exp_q.push_back(12'h000); exp_q.push_back(12'h005);
    pulse_start();
    drain("rexec_fetch");
    begin
      int budget;
      budget = 20;
      while (n_exec == snap && budget > 0) begin
        @(negedge clk);
        #1;
        budget--;
      end
      check("rexec_launched", 32'(n_exec - snap), 32'd1);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rexec_pc", 32'(pc), 32'h000);
    check("rexec_req", 32'(imem_req), 32'h0);
    check("rexec_halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = obs_q.size();
    repeat (10) @(negedge clk);
    #1;
    check("rexec_no_fetch", 32'(obs_q.size() - snap), 32'd0);
    check("rexec_req_idle", 32'(imem_req), 32'h0);
    check("rexec_pc_idle", 32'(pc), 32'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
